// File: rtl/axi4lite_master_pkg.sv
// rtl/axi4lite_master_pkg.sv - shared AXI4-Lite response codes and master FSM states
package axi4lite_master_pkg;

    // AXI response encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Code reported on the command side when the watchdog aborts a transaction
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/axi4lite_watchdog.sv
// rtl/axi4lite_watchdog.sv - loadable down-counter flagging a stalled transaction
module axi4lite_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Loading N-1 makes expiry fire in the N-th enabled cycle, so the owner can
    // react on that edge and present its result in cycle N+1.
    localparam logic [CW-1:0] LOAD = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Reload on clear, otherwise count down while enabled and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    // A zero TIMEOUT_CYCLES disables the watchdog entirely
    assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == '0);

endmodule

// File: rtl/axi4lite_master.sv
// rtl/axi4lite_master.sv - single-outstanding AXI4-Lite initiator driven by a command/response stream
module axi4lite_master
    import axi4lite_master_pkg::*;
#(
    parameter int unsigned AXI_AWIDTH     = 4,
    parameter int unsigned AXI_DWIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESETN,

    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic                    CMD_WRITE,
    input  logic [AXI_AWIDTH-1:0]   CMD_ADDR,
    input  logic [AXI_DWIDTH-1:0]   CMD_WDATA,
    input  logic [AXI_DWIDTH/8-1:0] CMD_WSTRB,

    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [AXI_DWIDTH-1:0]   RSP_RDATA,
    output logic [1:0]              RSP_RESP,
    output logic                    RSP_TIMEOUT,

    output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
    output logic                    AXI_AWVALID,
    input  logic                    AXI_AWREADY,
    output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
    output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
    output logic                    AXI_WVALID,
    input  logic                    AXI_WREADY,
    input  logic [1:0]              AXI_BRESP,
    input  logic                    AXI_BVALID,
    output logic                    AXI_BREADY,
    output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
    output logic                    AXI_ARVALID,
    input  logic                    AXI_ARREADY,
    input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
    input  logic [1:0]              AXI_RRESP,
    input  logic                    AXI_RVALID,
    output logic                    AXI_RREADY
);

    state_t state;
    logic   cmd_accept;
    logic   wd_enable;
    logic   wd_expired;
    logic   b_hs;
    logic   r_hs;

    assign cmd_accept = (state == ST_IDLE) && CMD_VALID && CMD_READY;
    assign wd_enable  = (state == ST_WRITE) || (state == ST_READ);
    assign b_hs       = AXI_BVALID && AXI_BREADY;
    assign r_hs       = AXI_RVALID && AXI_RREADY;

    axi4lite_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (AXI_ACLK),
        .rst_n   (AXI_ARESETN),
        .clear   (cmd_accept),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Transaction FSM; every interface output is a register driven from here
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state       <= ST_IDLE;
            CMD_READY   <= 1'b0;
            RSP_VALID   <= 1'b0;
            RSP_RDATA   <= '0;
            RSP_RESP    <= RESP_OKAY;
            RSP_TIMEOUT <= 1'b0;
            AXI_AWADDR  <= '0;
            AXI_AWVALID <= 1'b0;
            AXI_WDATA   <= '0;
            AXI_WSTRB   <= '0;
            AXI_WVALID  <= 1'b0;
            AXI_BREADY  <= 1'b0;
            AXI_ARADDR  <= '0;
            AXI_ARVALID <= 1'b0;
            AXI_RREADY  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        CMD_READY <= 1'b0;
                        // Response-side ready goes up with the address so a
                        // responder waiting on ready can never deadlock us.
                        if (CMD_WRITE) begin
                            AXI_AWADDR  <= CMD_ADDR;
                            AXI_WDATA   <= CMD_WDATA;
                            AXI_WSTRB   <= CMD_WSTRB;
                            AXI_AWVALID <= 1'b1;
                            AXI_WVALID  <= 1'b1;
                            AXI_BREADY  <= 1'b1;
                            state       <= ST_WRITE;
                        end else begin
                            AXI_ARADDR  <= CMD_ADDR;
                            AXI_ARVALID <= 1'b1;
                            AXI_RREADY  <= 1'b1;
                            state       <= ST_READ;
                        end
                    end else begin
                        CMD_READY <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    // A real response wins over a watchdog expiring on the same edge
                    if (b_hs) begin
                        AXI_AWVALID <= 1'b0;
                        AXI_WVALID  <= 1'b0;
                        AXI_BREADY  <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        RSP_RDATA   <= '0;
                        RSP_RESP    <= AXI_BRESP;
                        RSP_TIMEOUT <= 1'b0;
                        state       <= ST_RESP;
                    end else if (wd_expired) begin
                        AXI_AWVALID <= 1'b0;
                        AXI_WVALID  <= 1'b0;
                        AXI_BREADY  <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        RSP_RDATA   <= '0;
                        RSP_RESP    <= RESP_TIMEOUT;
                        RSP_TIMEOUT <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        if (AXI_AWREADY) AXI_AWVALID <= 1'b0;
                        if (AXI_WREADY)  AXI_WVALID  <= 1'b0;
                    end
                end

                ST_READ: begin
                    if (r_hs) begin
                        AXI_ARVALID <= 1'b0;
                        AXI_RREADY  <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        RSP_RDATA   <= AXI_RDATA;
                        RSP_RESP    <= AXI_RRESP;
                        RSP_TIMEOUT <= 1'b0;
                        state       <= ST_RESP;
                    end else if (wd_expired) begin
                        AXI_ARVALID <= 1'b0;
                        AXI_RREADY  <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        RSP_RDATA   <= '0;
                        RSP_RESP    <= RESP_TIMEOUT;
                        RSP_TIMEOUT <= 1'b1;
                        state       <= ST_RESP;
                    end else if (AXI_ARREADY) begin
                        AXI_ARVALID <= 1'b0;
                    end
                end

                ST_RESP: begin
                    // Response fields hold until consumed; the next command is
                    // offered only from the following cycle.
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        CMD_READY <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_master.sv
// tb/tb_axi4lite_master.sv - directed vector bench for axi4lite_master with a register-file responder
module tb_axi4lite_master;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          CMD_VALID = 1'b0;
    logic          CMD_READY;
    logic          CMD_WRITE = 1'b0;
    logic [AW-1:0] CMD_ADDR = '0;
    logic [DW-1:0] CMD_WDATA = '0;
    logic [SW-1:0] CMD_WSTRB = '0;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b0;
    logic [DW-1:0] RSP_RDATA;
    logic [1:0]    RSP_RESP;
    logic          RSP_TIMEOUT;
    logic [AW-1:0] AXI_AWADDR;
    logic          AXI_AWVALID;
    logic          AXI_AWREADY = 1'b0;
    logic [DW-1:0] AXI_WDATA;
    logic [SW-1:0] AXI_WSTRB;
    logic          AXI_WVALID;
    logic          AXI_WREADY = 1'b0;
    logic [1:0]    AXI_BRESP = 2'b00;
    logic          AXI_BVALID = 1'b0;
    logic          AXI_BREADY;
    logic [AW-1:0] AXI_ARADDR;
    logic          AXI_ARVALID;
    logic          AXI_ARREADY = 1'b0;
    logic [DW-1:0] AXI_RDATA = '0;
    logic [1:0]    AXI_RRESP = 2'b00;
    logic          AXI_RVALID = 1'b0;
    logic          AXI_RREADY;

    axi4lite_master #(
        .AXI_AWIDTH     (AW),
        .AXI_DWIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .AXI_ACLK    (clk),
        .AXI_ARESETN (rst_n),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .CMD_WRITE   (CMD_WRITE),
        .CMD_ADDR    (CMD_ADDR),
        .CMD_WDATA   (CMD_WDATA),
        .CMD_WSTRB   (CMD_WSTRB),
        .RSP_VALID   (RSP_VALID),
        .RSP_READY   (RSP_READY),
        .RSP_RDATA   (RSP_RDATA),
        .RSP_RESP    (RSP_RESP),
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .AXI_AWADDR  (AXI_AWADDR),
        .AXI_AWVALID (AXI_AWVALID),
        .AXI_AWREADY (AXI_AWREADY),
        .AXI_WDATA   (AXI_WDATA),
        .AXI_WSTRB   (AXI_WSTRB),
        .AXI_WVALID  (AXI_WVALID),
        .AXI_WREADY  (AXI_WREADY),
        .AXI_BRESP   (AXI_BRESP),
        .AXI_BVALID  (AXI_BVALID),
        .AXI_BREADY  (AXI_BREADY),
        .AXI_ARADDR  (AXI_ARADDR),
        .AXI_ARVALID (AXI_ARVALID),
        .AXI_ARREADY (AXI_ARREADY),
        .AXI_RDATA   (AXI_RDATA),
        .AXI_RRESP   (AXI_RRESP),
        .AXI_RVALID  (AXI_RVALID),
        .AXI_RREADY  (AXI_RREADY)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Responder configuration: cycle (counted from issue, 1 = first cycle) at
    // which each channel becomes ready/valid.
    int         aw_at = 1, w_at = 1, b_at = 1, ar_at = 1, r_at = 1;
    bit         aw_never = 0, ar_never = 0, early = 0;
    logic [1:0] cfg_resp = 2'b00;

    bit          aw_done = 0, w_done = 0, ar_done = 0;
    int          t = 0;
    int          aw_hs_cyc = -1, w_hs_cyc = -1;
    int          stale_cnt = 0, overlap_cnt = 0;
    logic [31:0] mem [16];

    // Responder bookkeeping on the active edge: handshakes seen and register writes
    always @(posedge clk) begin
        if (!AXI_BREADY && !AXI_RREADY) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            ar_done <= 1'b0;
        end else begin
            if (AXI_AWVALID && AXI_AWREADY) begin aw_done <= 1'b1; aw_hs_cyc <= cyc; end
            if (AXI_WVALID && AXI_WREADY)   begin w_done <= 1'b1;  w_hs_cyc <= cyc;  end
            if (AXI_ARVALID && AXI_ARREADY) ar_done <= 1'b1;
            if (AXI_BVALID && AXI_BREADY && cfg_resp == 2'b00) begin
                for (int b = 0; b < SW; b++)
                    if (AXI_WSTRB[b]) mem[AXI_AWADDR][8*b +: 8] <= AXI_WDATA[8*b +: 8];
            end
        end
    end

    // Responder drive on the falling edge plus protocol monitors
    always @(negedge clk) begin
        if (AXI_BREADY || AXI_RREADY) t = t + 1; else t = 0;
        AXI_AWREADY = (t != 0) && !aw_never && (t >= aw_at) && !aw_done;
        AXI_WREADY  = (t != 0) && (t >= w_at) && !w_done;
        AXI_BVALID  = AXI_BREADY && (early || (aw_done && w_done)) && (t >= b_at);
        AXI_BRESP   = cfg_resp;
        AXI_ARREADY = (t != 0) && !ar_never && (t >= ar_at) && !ar_done;
        AXI_RVALID  = AXI_RREADY && (early || ar_done) && (t >= r_at);
        AXI_RRESP   = cfg_resp;
        AXI_RDATA   = mem[AXI_ARADDR];
        if ((AXI_AWVALID && aw_done) || (AXI_WVALID && w_done) || (AXI_ARVALID && ar_done))
            stale_cnt = stale_cnt + 1;
        if (RSP_VALID && CMD_READY)
            overlap_cnt = overlap_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_cfg(input int a, input int w, input int b, input int ar, input int r,
                           input bit awn, input bit arn, input bit e, input logic [1:0] rs);
        aw_at = a; w_at = w; b_at = b; ar_at = ar; r_at = r;
        aw_never = awn; ar_never = arn; early = e; cfg_resp = rs;
    endtask

    // Issue one command, wait for its response, optionally hold off RSP_READY
    task automatic do_cmd(input bit wr, input logic [3:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int hold,
                          input logic [31:0] exp_rd, input logic [1:0] exp_rs,
                          output logic [31:0] rd, output logic [1:0] rs, output logic to,
                          output int lat, output int acc);
        int n;
        rd = '0; rs = '0; to = 1'b0; lat = -1; acc = -1;
        @(negedge clk);
        CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = wd; CMD_WSTRB = ws;
        n = 0;
        while (!CMD_READY && n < 20) begin @(negedge clk); n++; end
        if (!CMD_READY) begin
            check("cmd_accept_bound", 0, 1);
            CMD_VALID = 1'b0;
            return;
        end
        acc = cyc;
        @(negedge clk);
        CMD_VALID = 1'b0;
        n = 0;
        while (!RSP_VALID && n < 40) begin @(negedge clk); n++; end
        if (!RSP_VALID) begin
            check("rsp_bound", 0, 1);
            return;
        end
        lat = cyc - acc;
        rd = RSP_RDATA; rs = RSP_RESP; to = RSP_TIMEOUT;
        for (int i = 0; i < hold; i++) begin
            check("hold_rsp_valid", RSP_VALID, 1);
            check("hold_cmd_ready", CMD_READY, 0);
            check("hold_rdata", RSP_RDATA, exp_rd);
            check("hold_resp", RSP_RESP, exp_rs);
            check("hold_axi_idle",
                  {AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY}, 0);
            @(negedge clk);
        end
        RSP_READY = 1'b1;
        @(negedge clk);
        RSP_READY = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_at, w_at, b_at, ar_at, r_at;
        bit          aw_never, ar_never, early;
        logic [1:0]  resp;
        logic [31:0] exp_rd;
        logic [1:0]  exp_rs;
        bit          exp_to;
        int          exp_lat;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        to;
        int          lat, acc;

        for (int i = 0; i < 16; i++) mem[i] = '0;

        //              wr addr  wdata         strb aw w  b  ar r  awn arn e  resp   exp_rd        rs     to lat
        vecs[0]  = '{0, 4'h0, 32'h0,        4'h0, 1, 1, 1, 1, 1, 0, 0, 0, 2'b00, 32'h00000000, 2'b00, 0, 3};
        vecs[1]  = '{1, 4'h0, 32'h00000041, 4'hF, 1, 1, 1, 1, 1, 0, 0, 0, 2'b00, 32'h00000000, 2'b00, 0, 3};
        vecs[2]  = '{0, 4'h0, 32'h0,        4'h0, 1, 1, 1, 1, 1, 0, 0, 0, 2'b00, 32'h00000041, 2'b00, 0, 3};
        vecs[3]  = '{1, 4'h4, 32'hDEADBEEF, 4'h5, 1, 1, 1, 1, 1, 0, 0, 0, 2'b00, 32'h00000000, 2'b00, 0, 3};
        vecs[4]  = '{0, 4'h4, 32'h0,        4'h0, 1, 1, 1, 1, 1, 0, 0, 0, 2'b00, 32'h00AD00EF, 2'b00, 0, 3};
        vecs[5]  = '{0, 4'h0, 32'h0,        4'h0, 1, 1, 1, 1, 1, 0, 0, 0, 2'b10, 32'h00000041, 2'b10, 0, 3};
        vecs[6]  = '{1, 4'h8, 32'h12345678, 4'hF, 1, 1, 1, 1, 1, 0, 0, 0, 2'b11, 32'h00000000, 2'b11, 0, 3};
        vecs[7]  = '{0, 4'h8, 32'h0,        4'h0, 1, 1, 1, 1, 1, 0, 0, 0, 2'b00, 32'h00000000, 2'b00, 0, 3};
        vecs[8]  = '{1, 4'hC, 32'hCAFEF00D, 4'hF, 1, 1, 1, 1, 1, 0, 0, 1, 2'b00, 32'h00000000, 2'b00, 0, 2};
        vecs[9]  = '{0, 4'hC, 32'h0,        4'h0, 1, 1, 1, 1, 1, 0, 0, 1, 2'b00, 32'hCAFEF00D, 2'b00, 0, 2};
        vecs[10] = '{1, 4'h2, 32'h000000AA, 4'h1, 4, 1, 6, 1, 1, 0, 0, 0, 2'b00, 32'h00000000, 2'b00, 0, 7};
        vecs[11] = '{0, 4'h2, 32'h0,        4'h0, 1, 1, 1, 3, 5, 0, 0, 0, 2'b00, 32'h000000AA, 2'b00, 0, 6};
        vecs[12] = '{1, 4'h6, 32'h00000001, 4'hF, 1, 1, 1, 1, 1, 1, 0, 0, 2'b00, 32'h00000000, 2'b11, 1, 9};
        vecs[13] = '{0, 4'h6, 32'h0,        4'h0, 1, 1, 1, 1, 1, 0, 1, 0, 2'b00, 32'h00000000, 2'b11, 1, 9};
        vecs[14] = '{0, 4'h0, 32'h0,        4'h0, 1, 1, 1, 1, 7, 0, 0, 0, 2'b00, 32'h00000041, 2'b00, 0, 8};

        // Reset values, then CMD_READY on the first edge after release
        @(negedge clk);
        @(negedge clk);
        check("reset_ctrl", {CMD_READY, RSP_VALID, RSP_TIMEOUT, AXI_AWVALID, AXI_WVALID,
                             AXI_BREADY, AXI_ARVALID, AXI_RREADY}, 0);
        check("reset_fields", {RSP_RDATA, RSP_RESP, AXI_AWADDR, AXI_ARADDR, AXI_WSTRB}, 0);
        check("reset_wdata", AXI_WDATA, 0);
        rst_n = 1'b1;
        #1 check("cmd_ready_before_edge", CMD_READY, 0);
        @(negedge clk);
        check("cmd_ready_after_release", CMD_READY, 1);

        for (int i = 0; i < 15; i++) begin
            set_cfg(vecs[i].aw_at, vecs[i].w_at, vecs[i].b_at, vecs[i].ar_at, vecs[i].r_at,
                    vecs[i].aw_never, vecs[i].ar_never, vecs[i].early, vecs[i].resp);
            do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0, 0, 0,
                   rd, rs, to, lat, acc);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_resp", i), rs, vecs[i].exp_rs);
            check($sformatf("vec%0d_timeout", i), to, vecs[i].exp_to);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        end
        check("no_valid_after_own_handshake", stale_cnt, 0);

        // Zero-wait write: AW and W both handshake on the first edge after accept
        set_cfg(1, 1, 1, 1, 1, 0, 0, 0, 2'b00);
        do_cmd(1, 4'h0, 32'h00000041, 4'hF, 0, 0, 0, rd, rs, to, lat, acc);
        check("aw_hs_cycle", aw_hs_cyc, acc + 1);
        check("w_hs_cycle", w_hs_cyc, acc + 1);
        check("aw_w_resp", rs, 2'b00);

        // Backpressure: response stays put for 5 cycles with RSP_READY low
        do_cmd(0, 4'h0, 32'h0, 4'h0, 5, 32'h00000041, 2'b00, rd, rs, to, lat, acc);
        check("bp_rdata", rd, 32'h00000041);

        // Stalled AW: timeout with every AXI valid/ready low while the response is held
        set_cfg(1, 1, 1, 1, 1, 1, 0, 0, 2'b00);
        do_cmd(1, 4'hE, 32'h00000055, 4'hF, 1, 32'h0, 2'b11, rd, rs, to, lat, acc);
        check("stall_latency", lat, TO + 1);
        check("stall_resp", rs, 2'b11);
        check("stall_timeout", to, 1);
        check("stall_mem_untouched", mem[14], 0);

        // Reset in the middle of a read
        set_cfg(1, 1, 1, 1, 1, 0, 1, 0, 2'b00);
        @(negedge clk);
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 4'h6;
        @(negedge clk);
        CMD_VALID = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midreset_arvalid_before", {AXI_ARVALID, AXI_RREADY, AXI_ARADDR}, {2'b11, 4'h6});
        #2 rst_n = 1'b0;
        #1;
        check("midreset_ctrl", {CMD_READY, RSP_VALID, RSP_TIMEOUT, AXI_AWVALID, AXI_WVALID,
                                AXI_BREADY, AXI_ARVALID, AXI_RREADY}, 0);
        check("midreset_fields", {RSP_RDATA, RSP_RESP, AXI_AWADDR, AXI_ARADDR, AXI_WSTRB}, 0);
        check("midreset_wdata", AXI_WDATA, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("midreset_cmd_ready_low", CMD_READY, 0);
        @(negedge clk);
        check("midreset_cmd_ready_high", CMD_READY, 1);

        set_cfg(1, 1, 1, 1, 1, 0, 0, 0, 2'b00);
        do_cmd(0, 4'h0, 32'h0, 4'h0, 0, 0, 0, rd, rs, to, lat, acc);
        check("post_reset_rdata", rd, 32'h00000041);
        check("post_reset_latency", lat, 3);

        check("rsp_valid_cmd_ready_overlap", overlap_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
